// File: rtl/uart_pkg.sv
// Shared UART types and constants: TX FSM states, stop/parity encodings, frame data width,
// and the parity helper used when the parity build option is on.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic STOP_ONE    = 1'b0;
  localparam logic STOP_TWO    = 1'b1;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam int   DATA_BITS   = 8;

  // Even parity is the XOR of the data; odd parity is its complement.
  function automatic logic parityOf(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte stream between the UART TX FIFO pop side and the serializer.
// The master offers a byte with valid; the slave accepts it with ready.
interface uart_tx_serializer_if;
  import uart_pkg::*;

  logic                 valid;
  logic                 ready;
  logic [DATA_BITS-1:0] payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: a load strobe starts a period of io_divider+1 cycles, and io_tick is high
// on the last cycle of that period. Also intended for the receive path.
module uart_baud_tick #(
  parameter int CLK_DIV_W = 16
) (
  input  logic                 io_mainClk,
  input  logic                 resetCtrl_systemReset_n,
  input  logic [CLK_DIV_W-1:0] io_divider,
  input  logic                 io_load,
  output logic                 io_tick
);

  logic [CLK_DIV_W-1:0] cnt;

  assign io_tick = (cnt == '0);

  // The counter holds at zero when idle; it is never decremented past zero.
  always_ff @(posedge io_mainClk or negedge resetCtrl_systemReset_n) begin
    if (!resetCtrl_systemReset_n) begin
      cnt <= '0;
    end else if (io_load) begin
      cnt <= io_divider;
    end else if (cnt != '0) begin
      cnt <= cnt - CLK_DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: frames one byte per handshake (start, 8 data LSB-first, optional parity when UART_TX_PARITY_EN, 1/2 stop); txd rises/falls the cycle after fire.
// Ready is high only in IDLE or on the final stop-bit cycle, which allows back-to-back frames.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_DIV_W = 16
) (
  input  logic                  io_mainClk,
  input  logic                  resetCtrl_systemReset_n,
  uart_tx_serializer_if.slave   io_input,
  input  logic [CLK_DIV_W-1:0]  io_clockDivider,
  input  logic                  io_stopBits,
`ifdef UART_TX_PARITY_EN
  input  logic                  io_parityEnable,
  input  logic                  io_parityOdd,
`endif
  output logic                  io_txd,
  output logic                  io_busy
);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shiftReg;
  logic [CLK_DIV_W-1:0] divReg;
  logic                 stopReg;
  logic                 stopCnt;
  logic [2:0]           bitCnt;
  logic                 tick;
  logic                 fire;
  logic                 lastStop;
  logic                 baudLoad;
  logic [CLK_DIV_W-1:0] baudDiv;
`ifdef UART_TX_PARITY_EN
  logic                 parityEnReg;
  logic                 parityBitReg;
`endif

  assign lastStop       = (stopCnt == stopReg);
  assign io_input.ready = (state == IDLE) | ((state == STOP) & tick & lastStop);
  assign fire           = io_input.valid & io_input.ready;

  // A new frame takes its divider straight from the input; in-flight bits use the latched copy.
  assign baudDiv  = fire ? io_clockDivider : divReg;
  assign baudLoad = fire | ((state != IDLE) & tick);

  uart_baud_tick #(
    .CLK_DIV_W (CLK_DIV_W)
  ) u_baudTick (
    .io_mainClk              (io_mainClk),
    .resetCtrl_systemReset_n (resetCtrl_systemReset_n),
    .io_divider              (baudDiv),
    .io_load                 (baudLoad),
    .io_tick                 (tick)
  );

  always_ff @(posedge io_mainClk or negedge resetCtrl_systemReset_n) begin
    if (!resetCtrl_systemReset_n) begin
      state        <= IDLE;
      io_txd       <= 1'b1;
      io_busy      <= 1'b0;
      shiftReg     <= '0;
      divReg       <= '0;
      stopReg      <= STOP_ONE;
      stopCnt      <= 1'b0;
      bitCnt       <= '0;
`ifdef UART_TX_PARITY_EN
      parityEnReg  <= 1'b0;
      parityBitReg <= 1'b0;
`endif
    end else if (fire) begin
      // Fire only happens from IDLE or on the last stop tick, so both paths share this entry.
      state        <= START;
      io_txd       <= 1'b0;
      io_busy      <= 1'b1;
      shiftReg     <= io_input.payload;
      divReg       <= io_clockDivider;
      stopReg      <= io_stopBits;
`ifdef UART_TX_PARITY_EN
      parityEnReg  <= io_parityEnable;
      parityBitReg <= parityOf(io_input.payload, io_parityOdd);
`endif
    end else begin
      case (state)
        IDLE: begin
          io_txd  <= 1'b1;
          io_busy <= 1'b0;
        end
        START: if (tick) begin
          state  <= DATA;
          bitCnt <= '0;
          io_txd <= shiftReg[0];
        end
        DATA: if (tick) begin
          if (bitCnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            if (parityEnReg) begin
              state  <= PARITY;
              io_txd <= parityBitReg;
            end else begin
              state   <= STOP;
              stopCnt <= 1'b0;
              io_txd  <= 1'b1;
            end
`else
            state   <= STOP;
            stopCnt <= 1'b0;
            io_txd  <= 1'b1;
`endif
          end else begin
            bitCnt   <= bitCnt + 3'd1;
            shiftReg <= shiftReg >> 1;
            io_txd   <= shiftReg[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (tick) begin
          state   <= STOP;
          stopCnt <= 1'b0;
          io_txd  <= 1'b1;
        end
`endif
        STOP: if (tick) begin
          if (!lastStop) begin
            stopCnt <= 1'b1;
          end else begin
            state   <= IDLE;
            io_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          io_txd  <= 1'b1;
          io_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
